// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU sequencer: instruction layout, op codes, FSM states.
package alu_sequencer_pkg;

  localparam int DATA_W  = 8;
  localparam int INSTR_W = 16;

  // ALU instruction codes plus the sequencer-only ADC (ALU ADD with carry-in)
  typedef enum logic [2:0] {
    ADD      = 3'd0,
    SUBTRACT = 3'd1,
    AND_OP   = 3'd2,
    OR_OP    = 3'd3,
    XOR_OP   = 3'd4,
    NOT_OP   = 3'd5,
    REG      = 3'd6,
    ADC      = 3'd7
  } seq_op_t;

  // imm8[1:0] doubles as rb when imm_sel=0
  typedef struct packed {
    seq_op_t     op;
    logic [1:0]  rd;
    logic [1:0]  ra;
    logic        imm_sel;
    logic [7:0]  imm8;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } seq_state_t;

  // ADC is not an ALU op; it runs as ADD with the carry flag fed in
  function automatic logic [2:0] alu_op_of(seq_op_t op);
    return (op == ADC) ? 3'(ADD) : 3'(op);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction-in and result-out handshakes of the ALU sequencer.
interface alu_sequencer_if;
  import alu_sequencer_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               res_valid;
  logic               res_ready;
  logic [DATA_W-1:0]  res_data;
  logic [1:0]         res_rd;

  // producer of instructions / consumer of results
  modport master (
    output in_valid, in_instr, res_ready,
    input  in_ready, res_valid, res_data, res_rd
  );

  // the sequencer side
  modport slave (
    input  in_valid, in_instr, res_ready,
    output in_ready, res_valid, res_data, res_rd
  );
endinterface

// File: rtl/alu_sequencer_regfile.sv
// General register file: two async read ports, one sync write port.
module alu_sequencer_regfile
  import alu_sequencer_pkg::*;
#(
  parameter int                NUM_REGS  = 4,
  parameter int                RIDX_W    = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RIDX_W-1:0] ra_i,
  input  logic [RIDX_W-1:0] rb_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic              we_i,
  input  logic [RIDX_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  assign rdata_a_o = regs_q[ra_i];
  assign rdata_b_o = regs_q[rb_i];

  // every register back to RESET_VAL on reset, single write otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Control side of the 8-bit ALU: decodes instructions, drives the ALU,
// writes results back and owns the architectural carry flag.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int                NUM_REGS  = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  alu_sequencer_if.slave    bus,
  output logic [DATA_W-1:0] alu_i_1,
  output logic [DATA_W-1:0] alu_i_2,
  output logic [2:0]        alu_op_code,
  output logic              alu_carry_ce,
  input  logic [DATA_W-1:0] alu_o_main,
  input  logic              alu_carry_out,
  output logic              carry_flag
);

  // register index field is only 2 bits wide, so larger files are capped
  localparam int RIDX_W = (NUM_REGS > 4) ? 2 : $clog2(NUM_REGS);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_DECODE = DECODE;
  localparam logic [1:0] S_EXEC   = EXEC;
  localparam logic [1:0] S_WB     = WB;

  logic [1:0]        state_q, state_d;
  instr_t            instr_q, instr_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [2:0]        aop_q, aop_d;
  logic              cin_q, cin_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [1:0]        res_rd_q, res_rd_d;
  logic              carry_q, carry_d;

  logic [DATA_W-1:0] rf_a, rf_b;
  logic              rf_we;

  alu_sequencer_regfile #(
    .NUM_REGS  (NUM_REGS),
    .RIDX_W    (RIDX_W),
    .RESET_VAL (RESET_VAL)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .ra_i      (instr_q.ra[RIDX_W-1:0]),
    .rb_i      (instr_q.imm8[RIDX_W-1:0]),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b),
    .we_i      (rf_we),
    .wa_i      (instr_q.rd[RIDX_W-1:0]),
    .wd_i      (alu_o_main)
  );

  // writeback lands at the end of EXEC, so the next instruction sees it
  assign rf_we = (state_q == S_EXEC);

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.res_valid = (state_q == S_WB);
  assign bus.res_data  = res_data_q;
  assign bus.res_rd    = res_rd_q;

  assign alu_i_1      = opa_q;
  assign alu_i_2      = opb_q;
  assign alu_op_code  = aop_q;
  assign alu_carry_ce = cin_q;
  assign carry_flag   = carry_q;

  // next-state for the IDLE -> DECODE -> EXEC -> WB loop
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    aop_d      = aop_q;
    cin_d      = cin_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    carry_d    = carry_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          instr_d = instr_t'(bus.in_instr);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // operands are latched here, so rd==ra==rb reads the old value
        opa_d   = rf_a;
        opb_d   = instr_q.imm_sel ? instr_q.imm8 : rf_b;
        aop_d   = alu_op_of(instr_q.op);
        cin_d   = (instr_q.op == ADC) ? carry_q : 1'b0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_data_d = alu_o_main;
        res_rd_d   = instr_q.rd;
        if (instr_q.op == ADD || instr_q.op == ADC) carry_d = alu_carry_out;
        state_d = S_WB;
      end
      default: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
    endcase
  end

  // state and datapath registers; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      aop_q      <= '0;
      cin_q      <= 1'b0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      carry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      aop_q      <= aop_d;
      cin_q      <= cin_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
      carry_q    <= carry_d;
    end
  end

endmodule
